// File: rtl/kyber_codec_pkg.sv
// Shared definitions for the Kyber codec blocks.
//   state_e       : frame FSM states of the bit-to-byte packer
//   KyberD        : default coefficient width in bits per input beat
//   KyberMaxBytes : default maximum frame length in bytes
package kyber_codec_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned KyberD        = 12;
    localparam int unsigned KyberMaxBytes = 384;

endpackage

// File: rtl/bits_to_bytes_stream_if.sv
// Handshake bundle for bits_to_bytes_stream.
//   start/len      : frame start request and frame length in bytes
//   busy/done      : frame in progress / one-cycle end-of-frame pulse
//   in_valid/in_ready/in_bits              : D-bit input beats, bit 0 first
//   out_valid/out_ready/out_byte/out_last  : packed LSB-first output bytes
// master drives the requests and beats; slave is the packer.
interface bits_to_bytes_stream_if #(
    parameter int unsigned D     = kyber_codec_pkg::KyberD,
    parameter int unsigned LEN_W = $clog2(kyber_codec_pkg::KyberMaxBytes + 1)
) ();

    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             in_valid;
    logic             in_ready;
    logic [D-1:0]     in_bits;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_byte;
    logic             out_last;

    modport master (
        output start, len, in_valid, in_bits, out_ready,
        input  busy, done, in_ready, out_valid, out_byte, out_last
    );

    modport slave (
        input  start, len, in_valid, in_bits, out_ready,
        output busy, done, in_ready, out_valid, out_byte, out_last
    );

endinterface

// File: rtl/bits_to_bytes_stream.sv
// Packs a stream of D-bit beats into LSB-first bytes for a frame of len bytes.
//   clk : clock, rising edge
//   rst : synchronous active-high reset; aborts any frame without a done pulse
//   bus : bits_to_bytes_stream_if slave (start/len/busy/done, input beats,
//         output bytes with out_last on the final byte)
// Bits of the final beat beyond 8*len are dropped. All outputs derive from
// registers only, so there is no combinational path from in_bits to out_byte.
module bits_to_bytes_stream
    import kyber_codec_pkg::*;
#(
    parameter int unsigned D         = KyberD,
    parameter int unsigned MAX_BYTES = KyberMaxBytes,
    parameter int unsigned LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input logic                   clk,
    input logic                   rst,
    bits_to_bytes_stream_if.slave bus
);

    // A beat is only taken with cnt <= 7, so cnt never exceeds D+7.
    localparam int unsigned AccW  = D + 7;
    localparam int unsigned CntW  = $clog2(AccW + 1);
    localparam int unsigned BitsW = LEN_W + 3;

    state_e            state;
    logic [AccW-1:0]   acc;
    logic [CntW-1:0]   cnt;
    logic [BitsW-1:0]  bits_left;
    logic [LEN_W-1:0]  bytes_left;

    logic              accept;
    logic              pop;
    logic              last;
    logic [CntW-1:0]   take;
    logic [CntW-1:0]   base;
    logic [AccW-1:0]   fresh;

    assign bus.in_ready  = (state == StRun) && (bits_left != '0) && (cnt < CntW'(8));
    assign bus.out_valid = (state == StRun) && (cnt >= CntW'(8));
    assign bus.out_byte  = acc[7:0];
    assign last          = (bytes_left == LEN_W'(1));
    assign bus.out_last  = bus.out_valid && last;
    assign bus.busy      = (state != StIdle);
    assign bus.done      = (state == StDone);

    assign accept = bus.in_valid && bus.in_ready;
    assign pop    = bus.out_valid && bus.out_ready;

    // New bits land just above whatever remains after this cycle's pop.
    assign base = pop ? (cnt - CntW'(8)) : cnt;

    always_comb begin
        // Only the bits still owed to the frame are kept from the final beat.
        if (bits_left >= BitsW'(D)) begin
            take = CntW'(D);
        end else begin
            take = CntW'(bits_left);
        end
        fresh = '0;
        for (int unsigned i = 0; i < D; i++) begin
            if (i < 32'(take)) begin
                fresh[i] = bus.in_bits[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            acc        <= '0;
            cnt        <= '0;
            bits_left  <= '0;
            bytes_left <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        bits_left  <= {bus.len, 3'b000};
                        bytes_left <= bus.len;
                        acc        <= '0;
                        cnt        <= '0;
                        state      <= (bus.len == '0) ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (pop || accept) begin
                        acc <= (pop ? (acc >> 8) : acc) | (accept ? (fresh << base) : '0);
                        cnt <= base + (accept ? take : '0);
                    end
                    if (accept) begin
                        bits_left <= (bits_left > BitsW'(D)) ? (bits_left - BitsW'(D)) : '0;
                    end
                    if (pop) begin
                        bytes_left <= bytes_left - LEN_W'(1);
                        if (last) begin
                            state <= StDone;
                        end
                    end
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bits_to_bytes_stream.sv
// Scoreboard bench: stimulus pushes {last, byte} into per-DUT queues, negedge
// monitors pop and compare on every output handshake and check the done pulse.
module tb_bits_to_bytes_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bits_to_bytes_stream_if #(.D(12), .LEN_W(9)) b12 ();
    bits_to_bytes_stream_if #(.D(1),  .LEN_W(9)) b1 ();

    bits_to_bytes_stream #(.D(12), .MAX_BYTES(384), .LEN_W(9)) u_dut12 (
        .clk (clk),
        .rst (rst),
        .bus (b12.slave)
    );

    bits_to_bytes_stream #(.D(1), .MAX_BYTES(384), .LEN_W(9)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    logic [8:0] q12[$];
    logic [8:0] q1[$];
    logic       exp_done12 = 1'b0;
    logic       exp_done1  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor for the D=12 instance.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst) begin
            if (b12.done || exp_done12) chk("done12", b12.done, exp_done12);
            exp_done12 = 1'b0;
            if (b12.out_valid && b12.out_ready) begin
                if (q12.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_byte12: got 0x%0h with nothing expected", b12.out_byte);
                end else begin
                    e = q12.pop_front();
                    chk("byte12", {23'd0, b12.out_last, b12.out_byte}, {23'd0, e});
                    if (e[8]) exp_done12 = 1'b1;
                end
            end
        end
    end

    // Monitor for the D=1 instance.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst) begin
            if (b1.done || exp_done1) chk("done1", b1.done, exp_done1);
            exp_done1 = 1'b0;
            if (b1.out_valid && b1.out_ready) begin
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_byte1: got 0x%0h with nothing expected", b1.out_byte);
                end else begin
                    e = q1.pop_front();
                    chk("byte1", {23'd0, b1.out_last, b1.out_byte}, {23'd0, e});
                    if (e[8]) exp_done1 = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start12(input int n);
        b12.start = 1'b1;
        b12.len   = 9'(n);
        tick();
        b12.start = 1'b0;
    endtask

    task automatic send12(input logic [11:0] v);
        int k = 0;
        b12.in_valid = 1'b1;
        b12.in_bits  = v;
        while (!b12.in_ready && k < 50) begin
            tick();
            k++;
        end
        if (!b12.in_ready) chk("in_ready_wait12", b12.in_ready, 1);
        tick();
        b12.in_valid = 1'b0;
    endtask

    task automatic drain12();
        int k = 0;
        while ((b12.busy || q12.size() != 0) && k < 100) begin
            tick();
            k++;
        end
        chk("drain_busy12", b12.busy, 0);
        chk("drain_queue12", q12.size(), 0);
    endtask

    task automatic start1(input int n);
        b1.start = 1'b1;
        b1.len   = 9'(n);
        tick();
        b1.start = 1'b0;
    endtask

    task automatic send1(input logic v);
        int k = 0;
        b1.in_valid   = 1'b1;
        b1.in_bits[0] = v;
        while (!b1.in_ready && k < 50) begin
            tick();
            k++;
        end
        if (!b1.in_ready) chk("in_ready_wait1", b1.in_ready, 1);
        tick();
        b1.in_valid = 1'b0;
    endtask

    task automatic drain1();
        int k = 0;
        while ((b1.busy || q1.size() != 0) && k < 100) begin
            tick();
            k++;
        end
        chk("drain_busy1", b1.busy, 0);
        chk("drain_queue1", q1.size(), 0);
    endtask

    task automatic frame_abc_123_len3();
        q12.push_back(9'h0BC);
        q12.push_back(9'h03A);
        q12.push_back(9'h112);
        start12(3);
        chk("busy_after_start", b12.busy, 1);
        send12(12'hABC);
        chk("latency_valid", b12.out_valid, 1);
        chk("latency_byte", b12.out_byte, 8'hBC);
        send12(12'h123);
        drain12();
    endtask

    initial begin
        logic [7:0] bits1;
        b12.start = 1'b0; b12.len = '0; b12.in_valid = 1'b0; b12.in_bits = '0;
        b12.out_ready = 1'b1;
        b1.start = 1'b0; b1.len = '0; b1.in_valid = 1'b0; b1.in_bits = '0;
        b1.out_ready = 1'b1;

        // Reset values
        repeat (2) tick();
        chk("rst_busy", b12.busy, 0);
        chk("rst_in_ready", b12.in_ready, 0);
        chk("rst_out_valid", b12.out_valid, 0);
        chk("rst_out_last", b12.out_last, 0);
        chk("rst_done", b12.done, 0);
        chk("rst_out_byte", b12.out_byte, 0);
        chk("rst_busy1", b1.busy, 0);
        rst = 1'b0;
        tick();

        // D=12, len=3
        frame_abc_123_len3();

        // D=1, len=1: bits 1,0,1,1,0,0,0,0 -> 0x0D
        bits1 = 8'h0D;
        q1.push_back(9'h10D);
        start1(1);
        for (int i = 0; i < 8; i++) send1(bits1[i]);
        drain1();

        // D=12, len=2: tail 0x12 of the second beat is discarded
        q12.push_back(9'h0BC);
        q12.push_back(9'h13A);
        start12(2);
        send12(12'hABC);
        send12(12'h123);
        chk("len2_in_ready_low", b12.in_ready, 0);
        chk("len2_last_byte", b12.out_byte, 8'h3A);
        drain12();

        // Backpressure: out_ready low for 5 cycles after first byte
        b12.out_ready = 1'b0;
        q12.push_back(9'h0BC);
        q12.push_back(9'h03A);
        q12.push_back(9'h112);
        start12(3);
        send12(12'hABC);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", b12.out_valid, 1);
            chk("hold_byte", b12.out_byte, 8'hBC);
            chk("hold_last", b12.out_last, 0);
            chk("hold_in_ready", b12.in_ready, 0);
            tick();
        end
        b12.out_ready = 1'b1;
        send12(12'h123);
        drain12();

        // len=0: done one cycle after start, no output
        start12(0);
        exp_done12 = 1'b1;
        chk("len0_done", b12.done, 1);
        chk("len0_busy", b12.busy, 1);
        chk("len0_out_valid", b12.out_valid, 0);
        tick();
        chk("len0_done_clear", b12.done, 0);
        chk("len0_idle", b12.busy, 0);
        chk("len0_out_valid2", b12.out_valid, 0);

        // Reset after first byte of a len=3 frame
        q12.push_back(9'h0BC);
        start12(3);
        send12(12'hABC);
        tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", b12.busy, 0);
        chk("abort_in_ready", b12.in_ready, 0);
        chk("abort_out_valid", b12.out_valid, 0);
        chk("abort_out_last", b12.out_last, 0);
        chk("abort_done", b12.done, 0);
        chk("abort_out_byte", b12.out_byte, 0);
        rst = 1'b0;
        chk("abort_queue", q12.size(), 0);
        tick();
        chk("abort_no_done", b12.done, 0);
        tick();
        chk("abort_no_done2", b12.done, 0);

        // Fresh frame after abort
        frame_abc_123_len3();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
